// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with registered reads,
// optional write bypass, optional hardwired zero entry and a post-reset clear sweep.
module regfile_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] rdReg1,
    input  logic [ADDR_W-1:0] rdReg2,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2,
    output logic              rdValid,
    input  logic [ADDR_W-1:0] wrReg,
    input  logic [DATA_W-1:0] wrData,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wr_hit;
    logic              rd_hit;

    assign wr_hit = cs & wr;
    assign rd_hit = cs & rd;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        rd_valid_d = 1'b0;
        we         = 1'b0;
        waddr      = wrReg;
        wdata      = wrData;
        unique case (state_q)
            CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                we = wr_hit && !(ZERO_REG != 0 && wrReg == '0);
                if (rd_hit) begin
                    rd_valid_d = 1'b1;
                    // Each port resolves zero-reg, then bypass, then array.
                    if (ZERO_REG != 0 && rdReg1 == '0) begin
                        rd_data1_d = '0;
                    end else if (BYPASS != 0 && wr_hit && rdReg1 == wrReg) begin
                        rd_data1_d = wrData;
                    end else begin
                        rd_data1_d = mem_q[rdReg1];
                    end
                    if (ZERO_REG != 0 && rdReg2 == '0) begin
                        rd_data2_d = '0;
                    end else if (BYPASS != 0 && wr_hit && rdReg2 == wrReg) begin
                        rd_data2_d = wrData;
                    end else begin
                        rd_data2_d = mem_q[rdReg2];
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
        if (rst) begin
            we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Array has no reset; the sweep provides the known-zero state.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdData1 = rd_data1_q;
    assign rdData2 = rd_data2_q;
    assign rdValid = rd_valid_q;
    assign busy    = rst || (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench: default build, a ZERO_REG=1/BYPASS=0 build sharing its
// stimulus, and a 32x32 ZERO_REG=1 build with its own stimulus.
module tb_regfile_param;

    logic        clk;
    logic        rst;
    logic        cs, rd, wr;
    logic [2:0]  r1, r2, wa;
    logic [15:0] wd;
    logic [15:0] d1_a, d2_a, d1_b, d2_b;
    logic        v_a, v_b, busy_a, busy_b;

    logic        c_rst, c_cs, c_rd, c_wr;
    logic [4:0]  c_r1, c_r2, c_wa;
    logic [31:0] c_wd, d1_c, d2_c;
    logic        v_c, busy_c;

    int checks = 0;
    int failures = 0;
    int n;

    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr),
        .rdReg1(r1), .rdReg2(r2), .rdData1(d1_a), .rdData2(d2_a),
        .rdValid(v_a), .wrReg(wa), .wrData(wd), .busy(busy_a)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr),
        .rdReg1(r1), .rdReg2(r2), .rdData1(d1_b), .rdData2(d2_b),
        .rdValid(v_b), .wrReg(wa), .wrData(wd), .busy(busy_b)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_c (
        .clk(clk), .rst(c_rst), .cs(c_cs), .rd(c_rd), .wr(c_wr),
        .rdReg1(c_r1), .rdReg2(c_r2), .rdData1(d1_c), .rdData2(d2_c),
        .rdValid(v_c), .wrReg(c_wa), .wrData(c_wd), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cs = 0; rd = 0; wr = 0;
        r1 = 0; r2 = 0; wa = 0; wd = 0;
        c_rst = 1'b1; c_cs = 0; c_rd = 0; c_wr = 0;
        c_r1 = 0; c_r2 = 0; c_wa = 0; c_wd = 0;

        tick();
        tick();
        chk("rst_d1_a", 32'(d1_a), 32'h0);
        chk("rst_d2_a", 32'(d2_a), 32'h0);
        chk("rst_valid_a", 32'(v_a), 32'h0);
        chk("rst_busy_a", 32'(busy_a), 32'h1);
        chk("rst_busy_b", 32'(busy_b), 32'h1);

        // release reset with an access attempt during the sweep
        rst = 1'b0;
        cs = 1; wr = 1; rd = 1; wa = 3; wd = 16'h5555; r1 = 3; r2 = 3;
        tick();
        n = 1;
        chk("busy_rd_ignored", 32'(v_a), 32'h0);
        chk("busy_rd_hold", 32'(d1_a), 32'h0);
        cs = 0; wr = 0; rd = 0;
        while (busy_a && n < 20) begin
            tick();
            n++;
        end
        chk("sweep_len_a", 32'(n), 32'd8);
        chk("sweep_done_b", 32'(busy_b), 32'h0);

        for (int i = 0; i < 8; i += 2) begin
            cs = 1; rd = 1; r1 = 3'(i); r2 = 3'(i + 1);
            tick();
            chk("clr_d1", 32'(d1_a), 32'h0);
            chk("clr_d2", 32'(d2_a), 32'h0);
            chk("b2b_valid", 32'(v_a), 32'h1);
        end
        cs = 0; rd = 0;

        // write then read latency
        cs = 1; wr = 1; wa = 5; wd = 16'hBEEF;
        tick();
        wr = 0; rd = 1; r1 = 5; r2 = 5;
        tick();
        chk("wr_rd_d1", 32'(d1_a), 32'hBEEF);
        chk("wr_rd_d2", 32'(d2_a), 32'hBEEF);
        chk("wr_rd_valid", 32'(v_a), 32'h1);
        rd = 0;
        tick();
        chk("hold_d1", 32'(d1_a), 32'hBEEF);
        chk("hold_valid", 32'(v_a), 32'h0);

        // bypass
        wr = 1; wa = 2; wd = 16'h1111;
        tick();
        wr = 1; wa = 2; wd = 16'h2222; rd = 1; r1 = 2; r2 = 4;
        tick();
        chk("byp1_d1_a", 32'(d1_a), 32'h2222);
        chk("byp0_d1_b", 32'(d1_b), 32'h1111);
        chk("byp1_d2_a", 32'(d2_a), 32'h0);
        chk("byp0_d2_b", 32'(d2_b), 32'h0);
        wr = 0; rd = 1; r1 = 2; r2 = 2;
        tick();
        chk("after_byp_a", 32'(d1_a), 32'h2222);
        chk("after_byp_b", 32'(d2_b), 32'h2222);

        // zero register
        rd = 0; wr = 1; wa = 0; wd = 16'hFFFF;
        tick();
        wr = 0; rd = 1; r1 = 0; r2 = 0;
        tick();
        chk("zero_off_a", 32'(d1_a), 32'hFFFF);
        chk("zero_on_b", 32'(d1_b), 32'h0);
        rd = 0;

        // fill, then reset mid-sweep twice
        for (int i = 0; i < 8; i++) begin
            wr = 1; wa = 3'(i); wd = 16'(16'h00A0 + i);
            tick();
        end
        wr = 0; rd = 1; r1 = 7; r2 = 6;
        tick();
        chk("fill_d1", 32'(d1_a), 32'h00A7);
        chk("fill_d2", 32'(d2_a), 32'h00A6);
        rd = 0; cs = 0;
        rst = 1;
        tick();
        chk("mid_rst_d1", 32'(d1_a), 32'h0);
        chk("mid_rst_busy", 32'(busy_a), 32'h1);
        rst = 0;
        tick();
        tick();
        tick();
        chk("mid_sweep_busy", 32'(busy_a), 32'h1);
        rst = 1;
        tick();
        rst = 0;
        n = 0;
        while (busy_a && n < 20) begin
            tick();
            n++;
        end
        chk("resweep_len", 32'(n), 32'd8);
        for (int i = 0; i < 8; i += 2) begin
            cs = 1; rd = 1; r1 = 3'(i); r2 = 3'(i + 1);
            tick();
            chk("resweep_d1", 32'(d1_a), 32'h0);
            chk("resweep_d2", 32'(d2_a), 32'h0);
        end
        cs = 0; rd = 0;

        // 32x32 build
        tick();
        c_rst = 0;
        n = 0;
        while (busy_c && n < 100) begin
            tick();
            n++;
        end
        chk("sweep_len_c", 32'(n), 32'd32);
        c_cs = 1; c_wr = 1; c_wa = 31; c_wd = 32'hDEADBEEF;
        tick();
        c_wr = 0; c_rd = 1; c_r1 = 31; c_r2 = 0;
        tick();
        chk("c_d1", d1_c, 32'hDEADBEEF);
        chk("c_d2", d2_c, 32'h0);
        chk("c_valid", 32'(v_c), 32'h1);
        c_wr = 1; c_wa = 0; c_wd = 32'hFFFFFFFF; c_rd = 1; c_r1 = 0; c_r2 = 31;
        tick();
        chk("c_zero_byp", d1_c, 32'h0);
        chk("c_d2_31", d2_c, 32'hDEADBEEF);
        c_cs = 0; c_rd = 1; c_wr = 1; c_wa = 31; c_wd = 32'h12345678;
        c_r1 = 31; c_r2 = 31;
        tick();
        chk("c_cs0_valid", 32'(v_c), 32'h0);
        chk("c_cs0_hold", d1_c, 32'h0);
        c_cs = 1; c_wr = 0; c_rd = 1; c_r1 = 31; c_r2 = 0;
        tick();
        chk("c_cs0_nowr", d1_c, 32'hDEADBEEF);
        chk("c_zero_rd", d2_c, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the CPU's 8x16 two-read/one-write register file.
- Width and depth are configurable. An optional hardwired-zero register 0 is available.
- Reads are registered (1-cycle) with selectable write-to-read bypass.
- After reset, a self-clearing sweep zeroes every entry before the block accepts accesses. Sits in the decode stage, between the instruction decoder and the ALU operand latches.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 0, 1 = entry 0 reads as zero and ignores writes
BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read; 0 = read returns the old contents

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
cs  input  1  chip select; gates rd and wr
rd  input  1  read strobe; both read ports are sampled when cs&rd
wr  input  1  write strobe; a write occurs when cs&wr
rdReg1  input  ADDR_W  read port 1 address
rdReg2  input  ADDR_W  read port 2 address
rdData1  output  DATA_W  registered read data, port 1
rdData2  output  DATA_W  registered read data, port 2
rdValid  output  1  1-cycle pulse: rdData1/2 updated this cycle
wrReg  input  ADDR_W  write address
wrData  input  DATA_W  write data
busy  output  1  1 while reset or clear sweep is in progress; accesses are ignored

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values at the edge where rst=1:
  - rdData1=0, rdData2=0, rdValid=0, busy=1
  - state=CLEAR, sweep counter=0
  - Array contents are not touched by rst itself.
- State machine has two states, CLEAR and RUN.
- CLEAR:
  - Each edge with rst=0 writes 0 to entry[counter] and increments the counter.
  - On the edge that clears entry DEPTH-1, the block moves to RUN and busy goes to 0.
  - The sweep takes exactly DEPTH edges after rst deasserts.
  - rst=1 mid-sweep restarts the counter at 0.
  - cs/rd/wr are ignored: no array writes from the ports, rdValid stays 0, rdData holds 0.
- RUN, write:
  - If cs&wr at an edge, entry[wrReg] <= wrData.
  - If ZERO_REG=1 and wrReg=0, the write is discarded.
- RUN, read:
  - If cs&rd at an edge, rdDataN <= contents of entry[rdRegN] as seen before that edge's write. rdValid <= 1 for one cycle.
  - Latency: data is valid on the cycle after the strobe.
  - If cs&rd is low, rdValid <= 0 and rdData1/2 hold their previous values.
- Bypass:
  - Applies when cs&rd&wr are all high in the same cycle and rdRegN==wrReg.
  - BYPASS=1: rdDataN <= wrData, unless ZERO_REG=1 and the address is 0, in which case the result is 0.
  - BYPASS=0: rdDataN <= old contents.
  - The two ports are resolved independently. Both ports may hit the same address.
- Zero register: with ZERO_REG=1, a read of address 0 always returns 0, regardless of array contents.
- cs=0: no read, no write, outputs hold, rdValid=0.
- No width conversion; all data paths are DATA_W. Addresses are used unsigned and need no range check, since DEPTH=2**ADDR_W.
- Back-to-back reads every cycle are supported, giving rdValid continuously high.

Test Plan:
- Reset/clear sweep: pulse rst 2 cycles, then release → busy=1 for exactly 8 edges, then 0. All 8 entries read 0x0000. A cs&wr to reg 3 issued during busy has no effect; reg 3 reads 0.
- Write/read latency: write 0xBEEF to reg 5, next cycle cs&rd with rdReg1=5, rdReg2=5 → one cycle later rdData1=rdData2=0xBEEF, rdValid=1 for one cycle. With rd low afterwards, data holds and rdValid=0.
- Bypass:
  - Reg 2 holds 0x1111.
  - Same cycle: wr reg 2 = 0x2222 and rd rdReg1=2, rdReg2=4.
  - BYPASS=1 → rdData1=0x2222. BYPASS=0 → rdData1=0x1111.
  - A following read of reg 2 returns 0x2222 in both configurations.
- Zero register: ZERO_REG=1, write 0xFFFF to reg 0 → a read of reg 0 returns 0x0000, including the same-cycle bypass case. ZERO_REG=0 → the read returns 0xFFFF.
- Reset mid-operation:
  - Fill regs 0–7 with 0x00A0+i.
  - Assert rst mid-sweep after 3 cleared entries, then reassert rst.
  - → The sweep restarts and takes a full 8 edges; all entries read 0 afterwards.
  - → rdData is 0 immediately after the rst edge.
- Parametrised build: DATA_W=32, ADDR_W=5 → sweep 32 cycles, write 0xDEADBEEF to reg 31 and read it back. cs=0 with rd=wr=1 → no change, rdValid=0.
